// File: rtl/alu_mc_if.sv
// Request/result channel of the multi-cycle ALU.
// The master drives operations in and the slave returns registered results and flags.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             carry_in;
    logic [3:0]       ex_cmd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [3:0]       sr_update;
    logic             busy;

    modport master (
        output in_valid, val1, val2, carry_in, ex_cmd, flush, out_ready,
        input  in_ready, out_valid, res, sr_update, busy
    );

    modport slave (
        input  in_valid, val1, val2, carry_in, ex_cmd, flush, out_ready,
        output in_ready, out_valid, res, sr_update, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake and registered results.
// Single-cycle data ops complete in one cycle; EX_MUL uses a WIDTH-step shift-add loop.
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_mc_if.slave     bus
);
    localparam logic [3:0] EX_MOV = 4'd0;
    localparam logic [3:0] EX_MVN = 4'd1;
    localparam logic [3:0] EX_ADD = 4'd2;
    localparam logic [3:0] EX_ADC = 4'd3;
    localparam logic [3:0] EX_SUB = 4'd4;
    localparam logic [3:0] EX_SBC = 4'd5;
    localparam logic [3:0] EX_AND = 4'd6;
    localparam logic [3:0] EX_ORR = 4'd7;
    localparam logic [3:0] EX_EOR = 4'd8;
    localparam logic [3:0] EX_CMP = 4'd9;
    localparam logic [3:0] EX_TST = 4'd10;
    localparam logic [3:0] EX_LDR = 4'd11;
    localparam logic [3:0] EX_STR = 4'd12;
    localparam logic [3:0] EX_MUL = 4'd15;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             mul_cin_q, mul_cin_d;

    logic             in_ready;
    logic             accept;
    logic             is_mul;
    logic             legal;
    logic             c_flag;
    logic             v_flag;
    logic [WIDTH:0]   wide;
    logic [WIDTH:0]   extra;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic [WIDTH-1:0] acc_step;
    logic             last_iter;

    assign in_ready      = rst_n && !busy_q && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign is_mul        = MUL_EN && (bus.ex_cmd == EX_MUL);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.res       = res_q;
    assign bus.sr_update = flags_q;

    // Single-cycle datapath at WIDTH+1 bits; flags packed as {Z,C,N,V}.
    always_comb begin
        wide    = '0;
        extra   = '0;
        alu_res = '0;
        c_flag  = bus.carry_in;
        v_flag  = 1'b0;
        legal   = 1'b1;
        case (bus.ex_cmd)
            EX_MOV: alu_res = bus.val2;
            EX_MVN: alu_res = ~bus.val2;
            EX_ADD, EX_ADC, EX_LDR: begin
                extra[0] = (bus.ex_cmd == EX_ADC) && bus.carry_in;
                wide     = {1'b0, bus.val1} + {1'b0, bus.val2} + extra;
                alu_res  = wide[WIDTH-1:0];
                c_flag   = wide[WIDTH];
                v_flag   = (bus.val1[WIDTH-1] == bus.val2[WIDTH-1]) &&
                           (alu_res[WIDTH-1] != bus.val1[WIDTH-1]);
            end
            EX_SUB, EX_SBC, EX_CMP, EX_STR: begin
                extra[0] = (bus.ex_cmd == EX_SBC) && !bus.carry_in;
                wide     = {1'b0, bus.val1} - {1'b0, bus.val2} - extra;
                alu_res  = wide[WIDTH-1:0];
                c_flag   = !wide[WIDTH];
                v_flag   = (bus.val1[WIDTH-1] != bus.val2[WIDTH-1]) &&
                           (alu_res[WIDTH-1] != bus.val1[WIDTH-1]);
            end
            EX_AND, EX_TST: alu_res = bus.val1 & bus.val2;
            EX_ORR:         alu_res = bus.val1 | bus.val2;
            EX_EOR:         alu_res = bus.val1 ^ bus.val2;
            default:        legal   = 1'b0;
        endcase
        alu_flags = legal ? {(alu_res == '0), c_flag, alu_res[WIDTH-1], v_flag} : 4'b0000;
        if (!legal) begin
            alu_res = '0;
        end
    end

    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic; a result is only published once the last multiply step is folded in.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        res_d       = res_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        mul_cin_d   = mul_cin_q;
        if (bus.flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                MUL: begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    acc_d    = acc_step;
                    cnt_d    = cnt_q + CW'(1);
                    if (last_iter) begin
                        cnt_d       = '0;
                        state_d     = DONE;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b1;
                        res_d       = acc_step;
                        flags_d     = {(acc_step == '0), mul_cin_q, acc_step[WIDTH-1], 1'b0};
                    end
                end
                default: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                    if (accept) begin
                        if (is_mul) begin
                            state_d     = MUL;
                            busy_d      = 1'b1;
                            out_valid_d = 1'b0;
                            mcand_d     = bus.val1;
                            mplier_d    = bus.val2;
                            acc_d       = '0;
                            mul_cin_d   = bus.carry_in;
                            cnt_d       = '0;
                        end else begin
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                            res_d       = alu_res;
                            flags_d     = alu_flags;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            flags_q     <= 4'b0000;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            mul_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            mul_cin_q   <= mul_cin_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases followed by random operations
// compared against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_MVN = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_ADC = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SBC = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_ORR = 4'd7;
    localparam logic [3:0] OP_EOR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_TST = 4'd10;
    localparam logic [3:0] OP_LDR = 4'd11;
    localparam logic [3:0] OP_STR = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd15;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] last_res;
    logic [3:0]  last_flags;
    int          last_busy;
    bit          seen;

    alu_mc_if #(.WIDTH(W)) bus();

    alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide integer arithmetic; flags returned as {Z,C,N,V}.
    function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, output logic [31:0] r, output logic [3:0] f);
        longint unsigned ua, ub, u;
        longint          sa, sb, s;
        logic            c, v;
        int              k;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        c = ci; v = 1'b0; r = '0; k = 0; u = 0; s = 0;
        case (cmd)
            OP_MOV: r = b;
            OP_MVN: r = ~b;
            OP_ADD, OP_LDR, OP_ADC: begin
                k = (cmd == OP_ADC && ci) ? 1 : 0;
                u = ua + ub + longint'(k);
                r = u[31:0];
                c = (u > 64'hFFFF_FFFF);
                s = sa + sb + longint'(k);
                v = (s > SMAX) || (s < SMIN);
            end
            OP_SUB, OP_CMP, OP_STR, OP_SBC: begin
                k = (cmd == OP_SBC && !ci) ? 1 : 0;
                c = (ua >= ub + longint'(k));
                u = ua - ub - longint'(k);
                r = u[31:0];
                s = sa - sb - longint'(k);
                v = (s > SMAX) || (s < SMIN);
            end
            OP_AND, OP_TST: r = a & b;
            OP_ORR:         r = a | b;
            OP_EOR:         r = a ^ b;
            OP_MUL: begin
                u = ua * ub;
                r = u[31:0];
            end
            default: begin
                r = '0;
                f = 4'b0000;
                return;
            end
        endcase
        f = {(r == 32'd0), c, r[31], v};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation, scrambles the inputs after acceptance, then checks latency and result.
    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input string tag);
        logic [31:0] er;
        logic [3:0]  ef;
        bit          ok;
        bit          rs;
        int          lat;
        int          busyc;
        model(cmd, a, b, ci, er, ef);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.ex_cmd    = cmd;
        bus.val1      = a;
        bus.val2      = b;
        bus.carry_in  = ci;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput({tag, "_accept"}, 64'(ok), 64'd1);
        if (!ok) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.val1     = $urandom;
        bus.val2     = $urandom;
        bus.carry_in = ~ci;
        bus.ex_cmd   = 4'($urandom);
        lat = 0; busyc = 0; rs = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.busy === 1'b1) busyc++;
            if (bus.in_ready === 1'b1) rs = 1'b1;
        end
        checkOutput({tag, "_latency"}, 64'(lat), (cmd == OP_MUL) ? 64'(W + 1) : 64'd1);
        checkOutput({tag, "_res"}, 64'(bus.res), 64'(er));
        checkOutput({tag, "_flags"}, 64'(bus.sr_update), 64'(ef));
        if (cmd == OP_MUL) begin
            checkOutput({tag, "_busy_cycles"}, 64'(busyc), 64'(W));
            checkOutput({tag, "_ready_while_busy"}, 64'(rs), 64'd0);
        end
        last_res   = bus.res;
        last_flags = bus.sr_update;
        last_busy  = busyc;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.val1      = '0;
        bus.val2      = '0;
        bus.carry_in  = 1'b0;
        bus.ex_cmd    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_res", 64'(bus.res), 64'd0);
        checkOutput("reset_flags", 64'(bus.sr_update), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", 64'(bus.in_ready), 64'd1);

        // Signed overflow on add.
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
        checkOutput("add_ovf_res_const", 64'(last_res), 64'h8000_0000);
        checkOutput("add_ovf_flags_const", 64'(last_flags), 64'b0011);

        // Equal subtract, then borrow-in on SBC.
        applyStimulus(OP_SUB, 32'd5, 32'd5, 1'b0, "sub_eq");
        checkOutput("sub_eq_res_const", 64'(last_res), 64'd0);
        checkOutput("sub_eq_flags_const", 64'(last_flags), 64'b1100);
        applyStimulus(OP_SBC, 32'd0, 32'd0, 1'b0, "sbc_borrow");
        checkOutput("sbc_res_const", 64'(last_res), 64'hFFFF_FFFF);
        checkOutput("sbc_flags_const", 64'(last_flags), 64'b0010);

        // Iterative multiply.
        applyStimulus(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b0, "mul");
        checkOutput("mul_res_const", 64'(last_res), 64'hFFFF_FFFF);
        checkOutput("mul_busy_const", 64'(last_busy), 64'd32);

        // Backpressure, then back-to-back results.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ex_cmd    = OP_ADD;
        bus.val1      = 32'd10;
        bus.val2      = 32'd20;
        bus.carry_in  = 1'b0;
        #1;
        checkOutput("bp_first_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.val1 = 32'd3;
        bus.val2 = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_hold", 64'(bus.out_valid), 64'd1);
            checkOutput("bp_res_hold", 64'(bus.res), 64'd30);
            checkOutput("bp_flags_hold", 64'(bus.sr_update), 64'b0000);
            checkOutput("bp_ready_low", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_release", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("b2b_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("b2b_res", 64'(bus.res), 64'd7);
        @(negedge clk);
        checkOutput("b2b_valid_clear", 64'(bus.out_valid), 64'd0);

        // Flush in the tenth multiply cycle.
        bus.in_valid = 1'b1;
        bus.ex_cmd   = OP_MUL;
        bus.val1     = 32'h0000_1234;
        bus.val2     = 32'h0000_5678;
        #1;
        checkOutput("flush_mul_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("flush_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy_after", 64'(bus.busy), 64'd0);
        checkOutput("flush_valid_after", 64'(bus.out_valid), 64'd0);
        checkOutput("flush_ready_after", 64'(bus.in_ready), 64'd1);
        checkOutput("flush_res_kept", 64'(bus.res), 64'd7);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checkOutput("flush_no_result", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of a multiply.
        bus.in_valid = 1'b1;
        bus.ex_cmd   = OP_MUL;
        bus.val1     = 32'd3;
        bus.val2     = 32'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("areset_busy", 64'(bus.busy), 64'd0);
        checkOutput("areset_res", 64'(bus.res), 64'd0);
        checkOutput("areset_flags", 64'(bus.sr_update), 64'd0);
        checkOutput("areset_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checkOutput("areset_no_result", 64'(seen), 64'd0);
        applyStimulus(OP_ADD, 32'd1, 32'd1, 1'b0, "post_reset_add");
        checkOutput("post_reset_add_const", 64'(last_res), 64'd2);

        // Randomized operations against the reference model.
        for (int t = 0; t < 40; t++) begin
            applyStimulus(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                          1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
